// File: rtl/tv80_bus_pkg.sv
// tv80_bus_pkg
// Shared types and constants for the TV80 strobe-bus to req/ack bridge.
//   - bus_state_t : bridge FSM states (IDLE/BUSY/IOHOLD/DONE)
//   - cyc_t       : decoded CPU cycle type (NONE/MRD/MWR/IORD/IOWR/INTA)
//   - IDLE_DI     : value presented on di after reset and on a forced completion
package tv80_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_IOHOLD = 2'd2,
        ST_DONE   = 2'd3
    } bus_state_t;

    typedef enum logic [2:0] {
        CYC_NONE = 3'd0,
        CYC_MRD  = 3'd1,
        CYC_MWR  = 3'd2,
        CYC_IORD = 3'd3,
        CYC_IOWR = 3'd4,
        CYC_INTA = 3'd5
    } cyc_t;

    localparam logic [7:0] IDLE_DI = 8'hFF;

endpackage

// File: rtl/tv80_bus_decode.sv
// tv80_bus_decode
// Purely combinational classifier of the Z80 strobe bus into one cycle type.
// Ports:
//   i_mreq_n, i_iorq_n, i_rd_n, i_wr_n, i_m1_n, i_rfsh_n : CPU strobes (active low)
//   o_cyc           : decoded cycle type (CYC_NONE when nothing to serve)
//   o_strobe_active : a decoded (non-refresh) bus cycle is being presented
module tv80_bus_decode
    import tv80_bus_pkg::*;
(
    input  logic i_mreq_n,
    input  logic i_iorq_n,
    input  logic i_rd_n,
    input  logic i_wr_n,
    input  logic i_m1_n,
    input  logic i_rfsh_n,
    output cyc_t o_cyc,
    output logic o_strobe_active
);

    // Interrupt acknowledge is checked first: it is the only cycle with
    // iorq_n and m1_n low together, and it carries neither rd_n nor wr_n.
    // Refresh (mreq_n and rfsh_n low) falls through to CYC_NONE.
    always_comb begin
        o_cyc = CYC_NONE;
        if (!i_iorq_n && !i_m1_n) begin
            o_cyc = CYC_INTA;
        end else if (!i_iorq_n && !i_rd_n) begin
            o_cyc = CYC_IORD;
        end else if (!i_iorq_n && !i_wr_n) begin
            o_cyc = CYC_IOWR;
        end else if (!i_mreq_n && i_rfsh_n && !i_rd_n) begin
            o_cyc = CYC_MRD;
        end else if (!i_mreq_n && i_rfsh_n && !i_wr_n) begin
            o_cyc = CYC_MWR;
        end
    end

    assign o_strobe_active = (o_cyc != CYC_NONE);

endmodule

// File: rtl/tv80_bus_bridge.sv
// tv80_bus_bridge
// Downstream bus stage for the negedge-strobed TV80 wrapper. Turns the Z80
// strobe bus into one synchronous req/ack port, returns read data on di and
// stretches CPU cycles through a combinational wait_n. Writes are posted: the
// CPU write itself never waits; only a later cycle stalls while a post is
// still outstanding.
//
// Parameters:
//   IO_WAIT     : extra cycles wait_n stays low after an I/O read completes (0..7)
//   TIMEOUT_CYC : ack watchdog limit in clk cycles (watchdog builds only)
// Optional feature macro:
//   TV80_BRIDGE_TIMEOUT_EN : enables the BUSY watchdog and the sticky bus_err
//
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   mreq_n/iorq_n/rd_n/wr_n    : CPU strobes (change on negedge clk)
//   m1_n/rfsh_n                : CPU fetch/intack and refresh markers
//   A, dout                    : CPU address and write data
//   di, wait_n                 : read data and wait back to the CPU
//   int_vec                    : vector returned on di during intack
//   bus_req/we/io/addr/wdata   : downstream request (held until bus_ack)
//   bus_rdata, bus_ack         : downstream read data and completion pulse
//   bus_err                    : sticky watchdog timeout flag
//   dbg_state                  : current FSM state
//
// Handshake: bus_req rises with the address/data/we/io fields already valid
// and stays high, fields stable, until the first clk edge that samples
// bus_ack high; bus_rdata is sampled on that same edge. bus_ack seen while no
// request is outstanding is ignored.
module tv80_bus_bridge
    import tv80_bus_pkg::*;
#(
    parameter int IO_WAIT     = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    output logic [7:0]  di,
    output logic        wait_n,
    input  logic [7:0]  int_vec,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_io,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err,
    output logic [1:0]  dbg_state
);

    localparam int IO_HOLD_LAST = (IO_WAIT > 0) ? IO_WAIT - 1 : 0;

    cyc_t       w_cyc;
    logic       w_strobe_active;

    bus_state_t r_state;
    bus_state_t w_state_nxt;

    cyc_t        r_cyc;
    logic        r_released;
    logic [2:0]  r_io_cnt;
    logic        r_req;
    logic        r_we;
    logic        r_io;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_di;

    logic       w_timeout;
    logic       w_ack_eff;
    logic [7:0] w_rdata_eff;
    logic       w_own_active;
    logic       w_all_high;
    logic       w_rd_like;
    logic       w_post_stall;

    logic       w_issue;
    logic       w_inta;
    logic       w_complete;
    logic       w_take_data;

    tv80_bus_decode u_decode (
        .i_mreq_n        (mreq_n),
        .i_iorq_n        (iorq_n),
        .i_rd_n          (rd_n),
        .i_wr_n          (wr_n),
        .i_m1_n          (m1_n),
        .i_rfsh_n        (rfsh_n),
        .o_cyc           (w_cyc),
        .o_strobe_active (w_strobe_active)
    );

    // The cycle that launched the transfer is still on the bus only if it has
    // never dropped since issue. Once it drops, a later cycle of the same type
    // is a new cycle, not the original one.
    assign w_own_active = (w_cyc == r_cyc) && !r_released;
    assign w_all_high   = mreq_n & iorq_n & rd_n & wr_n;
    assign w_ack_eff    = bus_ack | w_timeout;
    assign w_rdata_eff  = bus_ack ? bus_rdata : IDLE_DI;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_inta      = 1'b0;
        w_complete  = 1'b0;
        w_take_data = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cyc == CYC_INTA) begin
                    w_inta      = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_cyc != CYC_NONE) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_ack_eff) begin
                    w_complete = 1'b1;
                    if (r_we) begin
                        // Posted write whose strobe already ended needs no
                        // DONE handshake with the CPU.
                        w_state_nxt = w_own_active ? ST_DONE : ST_IDLE;
                    end else if (w_own_active) begin
                        w_take_data = 1'b1;
                        w_state_nxt = (r_io && (IO_WAIT > 0)) ? ST_IOHOLD : ST_DONE;
                    end else begin
                        // Read abandoned by the CPU: data is dropped.
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_IOHOLD: begin
                if (r_io_cnt == 3'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_all_high) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cyc      <= CYC_NONE;
            r_released <= 1'b0;
            r_io_cnt   <= 3'd0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_io       <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 8'h00;
            r_di       <= IDLE_DI;
        end else begin
            if (w_issue) begin
                r_cyc      <= w_cyc;
                r_released <= 1'b0;
                r_req      <= 1'b1;
                r_we       <= (w_cyc == CYC_MWR) || (w_cyc == CYC_IOWR);
                r_io       <= (w_cyc == CYC_IORD) || (w_cyc == CYC_IOWR);
                // I/O space only decodes the low address byte.
                if ((w_cyc == CYC_IORD) || (w_cyc == CYC_IOWR)) begin
                    r_addr <= {8'h00, A[7:0]};
                end else begin
                    r_addr <= A;
                end
                r_wdata    <= dout;
            end

            if (r_state == ST_BUSY && !w_own_active) begin
                r_released <= 1'b1;
            end

            if (w_inta) begin
                r_cyc <= CYC_INTA;
                r_di  <= int_vec;
            end

            if (w_complete) begin
                r_req <= 1'b0;
            end

            if (w_take_data) begin
                r_di     <= w_rdata_eff;
                r_io_cnt <= 3'(IO_HOLD_LAST);
            end else if (r_state == ST_IOHOLD && r_io_cnt != 3'd0) begin
                r_io_cnt <= r_io_cnt - 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // wait_n: reads/intack stall until DONE; any other cycle stalls only
    // behind a posted write that is still outstanding.
    // ------------------------------------------------------------------
    assign w_rd_like    = (w_cyc == CYC_MRD) || (w_cyc == CYC_IORD) || (w_cyc == CYC_INTA);
    assign w_post_stall = (r_state == ST_BUSY) && r_we && w_strobe_active && !w_own_active;
    assign wait_n       = !((w_rd_like && r_state != ST_DONE) || w_post_stall);

    // ------------------------------------------------------------------
    // Optional ack watchdog
    // ------------------------------------------------------------------
`ifdef TV80_BRIDGE_TIMEOUT_EN
    localparam logic [8:0] WD_LAST = 9'(TIMEOUT_CYC - 1);

    logic [8:0] r_wd_cnt;
    logic       r_err;

    // Fires on the TIMEOUT_CYC-th BUSY cycle without an ack; a real ack on
    // that same edge always wins.
    assign w_timeout = (r_state == ST_BUSY) && !bus_ack && (r_wd_cnt == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= 9'd0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != ST_BUSY || bus_ack || w_timeout) begin
                r_wd_cnt <= 9'd0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 9'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus_err = r_err;
`else
    assign w_timeout = 1'b0;
    // No watchdog: the flag can never set; the parameter stays referenced so
    // both builds share one parameter list.
    assign bus_err   = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    assign di        = r_di;
    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_io    = r_io;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_tv80_bus_bridge.sv
module tb_tv80_bus_bridge;
  import tv80_bus_pkg::*;

  localparam int IO_WAIT     = 1;
  localparam int TIMEOUT_CYC = 16;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic [15:0] a_bus;
  logic [7:0]  dout;
  logic [7:0]  di;
  logic        wait_n;
  logic [7:0]  int_vec;
  logic        bus_req, bus_we, bus_io;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  tv80_bus_bridge #(.IO_WAIT(IO_WAIT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .rfsh_n(rfsh_n), .A(a_bus), .dout(dout),
    .di(di), .wait_n(wait_n), .int_vec(int_vec),
    .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_di;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic gap_to_idle(input string name);
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({wait_n, bus_req, dbg_state} !== {1'b1, 1'b0, ST_IDLE})
      $display("FAIL %s: got wait_n=%b req=%b st=%0d want 1 0 %0d", name, wait_n, bus_req, dbg_state, ST_IDLE);
    else n_pass++;
  endtask

  task automatic do_read(input logic io, input logic [15:0] addr, input logic [7:0] rdata, input int ack_dly);
    int n;
    logic [7:0] exp;
    logic [15:0] exp_addr;
    exp_addr = io ? {8'h00, addr[7:0]} : addr;
    @(negedge clk);
    a_bus = addr; rd_n = 1'b0;
    if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
    exp_q.push_back(rdata);
    #1;
    n_checks++;
    if (wait_n !== 1'b0) $display("FAIL rd_wait_start: got %b want 0", wait_n);
    else n_pass++;
    @(posedge clk); #2;
    n_checks++;
    if ({bus_req, bus_we, bus_io, bus_addr} !== {1'b1, 1'b0, io, exp_addr})
      $display("FAIL rd_issue: got req=%b we=%b io=%b addr=%h want 1 0 %b %h", bus_req, bus_we, bus_io, bus_addr, io, exp_addr);
    else n_pass++;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      bus_ack = (n + 1 == ack_dly);
      bus_rdata = rdata;
      @(posedge clk); #2;
      n++;
      if (io && n == ack_dly) begin
        n_checks++;
        if ({di, wait_n} !== {rdata, 1'b0})
          $display("FAIL io_di_before_release: got di=%h wait_n=%b want %h 0", di, wait_n, rdata);
        else n_pass++;
      end
      if (wait_n === 1'b1) break;
    end
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 8'h00;
    n_checks++;
    if (n !== ack_dly + (io ? IO_WAIT : 0))
      $display("FAIL rd_latency: got %0d want %0d", n, ack_dly + (io ? IO_WAIT : 0));
    else n_pass++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (di !== exp) $display("FAIL rd_data: got %h want %h", di, exp);
    else n_pass++;
    n_checks++;
    if ({bus_req, bus_err} !== 2'b00) $display("FAIL rd_req_drop: got req=%b err=%b want 0 0", bus_req, bus_err);
    else n_pass++;
    last_di = exp;
    bus_idle();
    gap_to_idle("rd_return_idle");
  endtask

  task automatic do_write(input logic io, input logic [15:0] addr, input logic [7:0] data,
                          input int ack_dly, input int hold);
    int n;
    logic stall;
    logic [15:0] exp_addr;
    exp_addr = io ? {8'h00, addr[7:0]} : addr;
    @(negedge clk);
    a_bus = addr; dout = data; wr_n = 1'b0;
    if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
    #1;
    n_checks++;
    if (wait_n !== 1'b1) $display("FAIL wr_wait_start: got %b want 1", wait_n);
    else n_pass++;
    @(posedge clk); #2;
    n_checks++;
    if ({bus_req, bus_we, bus_io, bus_addr, bus_wdata} !== {1'b1, 1'b1, io, exp_addr, data})
      $display("FAIL wr_issue: got req=%b we=%b io=%b addr=%h wd=%h want 1 1 %b %h %h",
               bus_req, bus_we, bus_io, bus_addr, bus_wdata, io, exp_addr, data);
    else n_pass++;
    n = 0; stall = 1'b0;
    while (n < 40 && bus_req === 1'b1) begin
      @(negedge clk);
      bus_ack = (n + 1 == ack_dly);
      if (n + 1 == hold) bus_idle();
      @(posedge clk); #2;
      n++;
      if (wait_n !== 1'b1) stall = 1'b1;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    bus_idle();
    n_checks++;
    if (stall !== 1'b0) $display("FAIL wr_never_waits: got stall=%b want 0", stall);
    else n_pass++;
    n_checks++;
    if (n !== ack_dly) $display("FAIL wr_ack_cycles: got %0d want %0d", n, ack_dly);
    else n_pass++;
    n_checks++;
    if (di !== last_di) $display("FAIL wr_di_hold: got %h want %h", di, last_di);
    else n_pass++;
    gap_to_idle("wr_return_idle");
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus_idle();
    a_bus = 16'h0; dout = 8'h0; int_vec = 8'h0; bus_rdata = 8'h0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({di, wait_n, bus_req, bus_we, bus_io, bus_addr, bus_wdata, bus_err, dbg_state} !==
        {8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, ST_IDLE})
      $display("FAIL reset_values: got di=%h w=%b req=%b we=%b io=%b a=%h wd=%h err=%b st=%0d",
               di, wait_n, bus_req, bus_we, bus_io, bus_addr, bus_wdata, bus_err, dbg_state);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    last_di = 8'hFF;
  endtask

  task automatic test_mrd();
    do_read(1'b0, 16'h1234, 8'hA5, 3);
  endtask

  task automatic test_mwr();
    do_write(1'b0, 16'h8000, 8'h3C, 5, 2);
  endtask

  task automatic test_io_read();
    do_read(1'b1, 16'hFF42, 8'h5A, 1);
  endtask

  task automatic test_io_write();
    // Ack arrives while wr_n is still low: goes through DONE.
    do_write(1'b1, 16'h12AB, 8'h77, 1, 3);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    @(negedge clk);
    a_bus = 16'h8000; dout = 8'h3C; mreq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #2;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      bus_ack = (n == 6) || (n == 9);
      bus_rdata = (n == 9) ? 8'hC3 : 8'h00;
      if (n == 3) bus_idle();
      if (n == 4) begin
        a_bus = 16'h2000; mreq_n = 1'b0; rd_n = 1'b0;
        exp_q.push_back(8'hC3);
      end
      if (n == 10) bus_idle();
      @(posedge clk); #2;
      case (n)
        3: begin
          n_checks++;
          if ({wait_n, bus_req} !== 2'b11) $display("FAIL b2b_posted: got w=%b req=%b want 1 1", wait_n, bus_req);
          else n_pass++;
        end
        4, 5: begin
          n_checks++;
          if ({wait_n, bus_we, bus_req} !== 3'b011)
            $display("FAIL b2b_stall: got w=%b we=%b req=%b want 0 1 1", wait_n, bus_we, bus_req);
          else n_pass++;
        end
        6: begin
          n_checks++;
          if ({wait_n, bus_req} !== 2'b00) $display("FAIL b2b_wr_ack: got w=%b req=%b want 0 0", wait_n, bus_req);
          else n_pass++;
        end
        7: begin
          n_checks++;
          if ({bus_req, bus_we, bus_addr, wait_n} !== {1'b1, 1'b0, 16'h2000, 1'b0})
            $display("FAIL b2b_rd_issue: got req=%b we=%b a=%h w=%b want 1 0 2000 0", bus_req, bus_we, bus_addr, wait_n);
          else n_pass++;
        end
        8: begin
          n_checks++;
          if (wait_n !== 1'b0) $display("FAIL b2b_rd_wait: got %b want 0", wait_n);
          else n_pass++;
        end
        9: begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          n_checks++;
          if ({wait_n, di} !== {1'b1, exp}) $display("FAIL b2b_rd_data: got w=%b di=%h want 1 %h", wait_n, di, exp);
          else n_pass++;
          last_di = exp;
        end
        12: begin
          n_checks++;
          if (dbg_state !== ST_IDLE) $display("FAIL b2b_end_idle: got %0d want %0d", dbg_state, ST_IDLE);
          else n_pass++;
        end
        default: ;
      endcase
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_wr_after_wr();
    @(negedge clk);
    a_bus = 16'h8000; dout = 8'h11; mreq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #2;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      bus_ack = (n == 6) || (n == 8);
      if (n == 2) bus_idle();
      if (n == 4) begin
        a_bus = 16'h8001; dout = 8'h99; mreq_n = 1'b0; wr_n = 1'b0;
      end
      if (n == 10) bus_idle();
      @(posedge clk); #2;
      case (n)
        4, 5: begin
          n_checks++;
          if ({wait_n, bus_req, bus_addr} !== {1'b0, 1'b1, 16'h8000})
            $display("FAIL ww_stall: got w=%b req=%b a=%h want 0 1 8000", wait_n, bus_req, bus_addr);
          else n_pass++;
        end
        7: begin
          n_checks++;
          if ({wait_n, bus_req, bus_we, bus_addr, bus_wdata} !== {1'b1, 1'b1, 1'b1, 16'h8001, 8'h99})
            $display("FAIL ww_second_issue: got w=%b req=%b we=%b a=%h wd=%h want 1 1 1 8001 99",
                     wait_n, bus_req, bus_we, bus_addr, bus_wdata);
          else n_pass++;
        end
        8: begin
          n_checks++;
          if ({wait_n, bus_req, dbg_state} !== {1'b1, 1'b0, ST_DONE})
            $display("FAIL ww_ack_done: got w=%b req=%b st=%0d want 1 0 %0d", wait_n, bus_req, dbg_state, ST_DONE);
          else n_pass++;
        end
        12: begin
          n_checks++;
          if (dbg_state !== ST_IDLE) $display("FAIL ww_end_idle: got %0d want %0d", dbg_state, ST_IDLE);
          else n_pass++;
        end
        default: ;
      endcase
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_inta();
    logic [7:0] exp;
    @(negedge clk);
    int_vec = 8'hE7; iorq_n = 1'b0; m1_n = 1'b0;
    exp_q.push_back(8'hE7);
    #1;
    n_checks++;
    if (wait_n !== 1'b0) $display("FAIL inta_wait: got %b want 0", wait_n);
    else n_pass++;
    @(posedge clk); #2;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if ({wait_n, bus_req, di} !== {1'b1, 1'b0, exp})
      $display("FAIL inta_vector: got w=%b req=%b di=%h want 1 0 %h", wait_n, bus_req, di, exp);
    else n_pass++;
    last_di = exp;
    @(negedge clk);
    bus_idle();
    gap_to_idle("inta_return_idle");
  endtask

  task automatic test_refresh();
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    a_bus = 16'h007F; mreq_n = 1'b0; rfsh_n = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      bus_ack = (n == 1);  // stray ack while idle
      bus_rdata = 8'h99;
      @(posedge clk); #2;
      if ({wait_n, bus_req} !== 2'b10) bad = 1'b1;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    bus_idle();
    n_checks++;
    if (bad !== 1'b0) $display("FAIL refresh_ignored: got bad=%b want 0", bad);
    else n_pass++;
    n_checks++;
    if (di !== last_di) $display("FAIL idle_ack_ignored: got di=%h want %h", di, last_di);
    else n_pass++;
  endtask

  task automatic test_cpu_abort();
    @(negedge clk);
    a_bus = 16'h4444; mreq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #2;
    @(negedge clk);
    bus_idle();
    @(posedge clk); #2;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 8'h11;
    @(posedge clk); #2;
    n_checks++;
    if ({bus_req, dbg_state, wait_n, di} !== {1'b0, ST_IDLE, 1'b1, last_di})
      $display("FAIL abort_discard: got req=%b st=%0d w=%b di=%h want 0 %0d 1 %h",
               bus_req, dbg_state, wait_n, di, ST_IDLE, last_di);
    else n_pass++;
    @(negedge clk);
    bus_ack = 1'b0;
  endtask

`ifdef TV80_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    @(negedge clk);
    a_bus = 16'h0100; mreq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #2;
    n = 0;
    while (n < 60 && bus_req === 1'b1) begin
      @(posedge clk); #2;
      n++;
    end
    n_checks++;
    if ({n, di, bus_err, wait_n} !== {TIMEOUT_CYC, 8'hFF, 1'b1, 1'b1})
      $display("FAIL timeout: got n=%0d di=%h err=%b w=%b want %0d ff 1 1", n, di, bus_err, wait_n, TIMEOUT_CYC);
    else n_pass++;
    last_di = 8'hFF;
    @(negedge clk);
    bus_idle();
    gap_to_idle("timeout_idle");
    n_checks++;
    if (bus_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", bus_err);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    @(negedge clk);
    a_bus = 16'h5555; dout = 8'h66; mreq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    bus_idle();
    #1;
    n_checks++;
    if ({di, wait_n, bus_req, bus_we, bus_io, bus_addr, bus_wdata, bus_err, dbg_state} !==
        {8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, ST_IDLE})
      $display("FAIL reset_mid: got di=%h w=%b req=%b we=%b io=%b a=%h wd=%h err=%b st=%0d",
               di, wait_n, bus_req, bus_we, bus_io, bus_addr, bus_wdata, bus_err, dbg_state);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    last_di = 8'hFF;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mrd();
    test_mwr();
    test_back_to_back();
    test_wr_after_wr();
    test_io_read();
    test_io_write();
    test_inta();
    test_refresh();
    test_cpu_abort();
    do_read(1'b0, 16'h7FFF, 8'h00, 1);
`ifdef TV80_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
